// File: rtl/serial_add_scheduler_if.sv
// Request/result bundle for serial_add_scheduler: four requesters in, one result channel out.
// res_ovf exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_add_scheduler_if #(parameter int WIDTH = 4);
  logic [3:0]         req_valid;
  logic [3:0]         req_ready;
  logic [4*WIDTH-1:0] req_a;
  logic [4*WIDTH-1:0] req_b;
  logic [3:0]         req_cin;
  logic               res_valid;
  logic               res_ready;
  logic [1:0]         res_id;
  logic [WIDTH-1:0]   res_sum;
  logic               res_cout;
`ifdef SERIAL_ADD_OVF_EN
  logic               res_ovf;
`endif
  logic               busy;

  modport slave (
`ifdef SERIAL_ADD_OVF_EN
    output res_ovf,
`endif
    input  req_valid, req_a, req_b, req_cin, res_ready,
    output req_ready, res_valid, res_id, res_sum, res_cout, busy
  );

  modport master (
`ifdef SERIAL_ADD_OVF_EN
    input  res_ovf,
`endif
    output req_valid, req_a, req_b, req_cin, res_ready,
    input  req_ready, res_valid, res_id, res_sum, res_cout, busy
  );
endinterface

// File: rtl/serial_add_scheduler.sv
// Round-robin scheduler sharing one bit-serial full adder among four requesters.
// Optional SERIAL_ADD_OVF_EN adds a two's-complement overflow flag to the result.
module serial_add_scheduler #(
  parameter int WIDTH = 4
) (
  input logic                 clk,
  input logic                 reset,
  serial_add_scheduler_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic [1:0]       id_q, id_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [3:0][WIDTH-1:0] op_a, op_b;
  assign op_a = bus.req_a;
  assign op_b = bus.req_b;

  // Rotating priority search starting at rr_ptr
  logic [3:0] gnt;
  logic [1:0] win;
  logic       found;
  always_comb begin
    logic [1:0] idx;
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr_q + 2'(k);
      if (!found && bus.req_valid[idx]) begin
        gnt[idx] = 1'b1;
        win      = idx;
        found    = 1'b1;
      end
    end
  end

  logic fa_s, fa_c;
  assign fa_s = a_q[0] ^ b_q[0] ^ carry_q;
  assign fa_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    count_d  = count_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    id_d     = id_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          a_d     = op_a[win];
          b_d     = op_b[win];
          carry_d = bus.req_cin[win];
          id_d    = win;
          count_d = '0;
          sum_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        carry_d = fa_c;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        count_d = count_q + 1'b1;
        if (count_q == LAST) begin
          cout_d  = fa_c;
`ifdef SERIAL_ADD_OVF_EN
          // carry_q here is the carry into the MSB
          ovf_d   = carry_q ^ fa_c;
`endif
          count_d = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.res_ready) begin
          rr_ptr_d = id_q + 2'd1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      count_q  <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      id_q     <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      id_q     <= id_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Grant is masked while reset is held so nothing looks granted during reset
  assign bus.req_ready = (state_q == S_IDLE && !reset) ? gnt : 4'b0000;
  assign bus.res_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.res_sum   = sum_q;
  assign bus.res_cout  = cout_q;
  assign bus.res_id    = id_q;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.res_ovf   = ovf_q;
`endif
endmodule

// File: tb/tb_serial_add_scheduler.sv
// Scoreboard bench for serial_add_scheduler: a cycle model predicts grants, busy/valid timing and results.
module tb_serial_add_scheduler;
  localparam int W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  serial_add_scheduler_if #(.WIDTH(W)) bus();
  serial_add_scheduler #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [1:0]   id;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sbq[$];
  int   gnt_log[$];
  int   gnt_time[$];
  int   checks = 0;
  int   errors = 0;
  int   cnt = -1;
  int   ptr = 0;
  int   nres = 0;
  int   cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Model state used only by the monitor
  logic [3:0] er;
  int   win, ia, ib, ic, full, sa, sbv, ss;
  exp_t e;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      cnt = -1;
      ptr = 0;
      sbq.delete();
    end else begin
      if (cnt >= 0 && cnt <= W) cnt++;
      chk("busy", bus.busy, cnt >= 1);
      chk("res_valid", bus.res_valid, cnt == W + 1);
      er  = 4'b0000;
      win = -1;
      if (cnt == -1)
        for (int k = 0; k < 4; k++) begin
          int idx;
          idx = (ptr + k) % 4;
          if (win < 0 && bus.req_valid[idx]) begin
            win = idx;
            er[idx] = 1'b1;
          end
        end
      chk("req_ready", bus.req_ready, er);
      if (win >= 0) begin
        ia   = int'(bus.req_a[win*W +: W]);
        ib   = int'(bus.req_b[win*W +: W]);
        ic   = int'(bus.req_cin[win]);
        full = ia + ib + ic;
        sa   = (ia >= (1 << (W-1))) ? ia - (1 << W) : ia;
        sbv  = (ib >= (1 << (W-1))) ? ib - (1 << W) : ib;
        ss   = sa + sbv + ic;
        e.id   = 2'(win);
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1)));
        sbq.push_back(e);
        gnt_log.push_back(win);
        gnt_time.push_back(cyc);
        cnt = 0;
      end else if (cnt == W + 1 && bus.res_valid) begin
        if (sbq.size() == 0) chk("sb_empty", 32'(sbq.size()), 1);
        else begin
          e = sbq[0];
          chk("res_id", bus.res_id, e.id);
          chk("res_sum", bus.res_sum, e.sum);
          chk("res_cout", bus.res_cout, e.cout);
`ifdef SERIAL_ADD_OVF_EN
          chk("res_ovf", bus.res_ovf, e.ovf);
`endif
          if (bus.res_ready) begin
            void'(sbq.pop_front());
            ptr = (int'(e.id) + 1) % 4;
            cnt = -1;
            nres++;
          end
        end
      end
    end
  end

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
    bus.req_cin[i]      = c;
  endtask

  task automatic wait_grants(input int n);
    int t = 0;
    while (gnt_log.size() < n && t < 200) begin @(posedge clk); t++; end
    if (gnt_log.size() < n) chk("grant_timeout", 32'(gnt_log.size()), 32'(n));
  endtask

  task automatic drain();
    int t = 0;
    while ((sbq.size() != 0 || cnt != -1) && t < 300) begin @(posedge clk); t++; end
    if (sbq.size() != 0 || cnt != -1) chk("drain_timeout", 32'(sbq.size()), 0);
  endtask

  task automatic single(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int n0;
    n0 = gnt_log.size();
    @(posedge clk); #1;
    set_op(i, a, b, c);
    bus.req_valid = 4'(1 << i);
    wait_grants(n0 + 1);
    #1 bus.req_valid = 4'b0000;
    drain();
  endtask

  initial begin
    int n0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    bus.res_ready = 1'b1;
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_sum", bus.res_sum, 0);
    chk("rst_res_cout", bus.res_cout, 0);
    chk("rst_res_id", bus.res_id, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    single(0, 4'h5, 4'h3, 1'b0);
    single(2, 4'hF, 4'h1, 1'b0);
    single(2, 4'hF, 4'hF, 1'b1);
    single(3, 4'h9, 4'h6, 1'b1);

    // All four held valid: strict rotation, one grant every W+2 cycles
    n0 = gnt_log.size();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) set_op(i, 4'($urandom), 4'($urandom), 1'($urandom));
    bus.req_valid = 4'b1111;
    wait_grants(n0 + 6);
    #1 bus.req_valid = 4'b0000;
    drain();
    for (int j = 0; j < 6; j++) chk("rr_order", 32'(gnt_log[n0+j]), 32'(j % 4));
    for (int j = 1; j < 6; j++) chk("rr_gap", 32'(gnt_time[n0+j] - gnt_time[n0+j-1]), W + 2);

    // Backpressure in DONE with everyone requesting
    n0 = gnt_log.size();
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    bus.req_valid = 4'b1111;
    begin
      int t = 0;
      while (!bus.res_valid && t < 50) begin @(posedge clk); t++; end
    end
    repeat (5) @(posedge clk);
    chk("bp_no_grant", 32'(gnt_log.size()), 32'(n0 + 1));
    #1 bus.res_ready = 1'b1;
    wait_grants(n0 + 2);
    #1 bus.req_valid = 4'b0000;
    chk("bp_first_id", 32'(gnt_log[n0]), 2);
    chk("bp_next_id", 32'(gnt_log[n0+1]), 3);
    drain();

    // Reset two shift edges into an operation
    n0 = gnt_log.size();
    @(posedge clk); #1;
    set_op(3, 4'hA, 4'h7, 1'b0);
    bus.req_valid = 4'b1000;
    wait_grants(n0 + 1);
    #1 bus.req_valid = 4'b0000;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    bus.req_valid = 4'b1010;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_res_valid", bus.res_valid, 0);
    chk("mid_rst_res_sum", bus.res_sum, 0);
    chk("mid_rst_req_ready", bus.req_ready, 0);
    set_op(1, 4'h6, 4'h6, 1'b1);
    @(posedge clk); #2 reset = 1'b0;
    n0 = gnt_log.size();
    wait_grants(n0 + 1);
    #1 bus.req_valid = 4'b0000;
    chk("post_rst_grant", 32'(gnt_log[n0]), 1);
    drain();

    // Random traffic with operand churn and intermittent res_ready
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) set_op(i, 4'($urandom), 4'($urandom), 1'($urandom));
      bus.req_valid = 4'($urandom_range(0, 15));
      bus.res_ready = ($urandom % 4) != 0;
    end
    @(posedge clk); #1;
    bus.req_valid = 4'b0000;
    bus.res_ready = 1'b1;
    drain();

`ifdef SERIAL_ADD_OVF_EN
    single(1, 4'h7, 4'h1, 1'b0);
    single(1, 4'h8, 4'h8, 1'b0);
    single(1, 4'h3, 4'h2, 1'b0);
`endif
    single(0, 4'h0, 4'h0, 1'b0);
    single(1, 4'hF, 4'hF, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
